// File: rtl/board_reset_ctrl.sv
// board_reset_ctrl: button synchroniser/debouncer, reset stretcher and clear-screen gate.
// Ports: clk25, rst_n (async, active-low) in; btn_reset_n, btn_cls_n raw buttons in;
//        sys_rst_n, cls_level, cls_pulse, rst_state[1:0] out.
// Optional: define LONG_PRESS_RESET_EN to let a long clear-button hold force a reset.
`timescale 1ns/1ps
module board_reset_ctrl #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int POR_CYCLES        = 65536,
    parameter int LONG_PRESS_CYCLES = 75000000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       btn_reset_n,
    input  logic       btn_cls_n,
    output logic       sys_rst_n,
    output logic       cls_level,
    output logic       cls_pulse,
    output logic [1:0] rst_state
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_POR     = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_STRETCH = 2'd3
    } state_t;

    state_t state;

    // index 0 = reset button, index 1 = clear button; 1 = released
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0][DB_W-1:0]        db_cnt;
    logic [1:0]                  db;
    logic [1:0]                  raw;

    logic [POR_W-1:0] por_cnt;
    logic             cls_prev;
    logic             long_hit;
    logic             rst_db;
    logic             cls_db;

    assign raw    = {btn_cls_n, btn_reset_n};
    assign rst_db = db[0];
    assign cls_db = db[1];

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            db_cnt <= '0;
            db     <= 2'b11;
        end else begin
            for (int b = 0; b < 2; b++) begin
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
                if (sync_q[b][SYNC_STAGES-1] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_MAX) begin
                    // last of DEBOUNCE_CYCLES differing edges: accept
                    db[b]     <= ~db[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

`ifdef LONG_PRESS_RESET_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);

    logic [LP_W-1:0] hold_cnt;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != S_RUN || cls_db) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LP_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign long_hit = (hold_cnt == LP_MAX);
`else
    logic lp_unused;
    assign lp_unused = (LONG_PRESS_CYCLES == 0);
    assign long_hit  = 1'b0;
`endif

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_POR;
            por_cnt   <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            unique case (state)
                S_POR, S_STRETCH: begin
                    if (!rst_db) begin
                        state   <= S_HOLD;
                        por_cnt <= '0;
                    end else if (por_cnt == POR_MAX) begin
                        state     <= S_RUN;
                        por_cnt   <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        por_cnt <= por_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!rst_db) begin
                        state     <= S_HOLD;
                        sys_rst_n <= 1'b0;
                    end else if (long_hit) begin
                        state     <= S_STRETCH;
                        por_cnt   <= '0;
                        sys_rst_n <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (rst_db) begin
                        state   <= S_STRETCH;
                        por_cnt <= '0;
                    end
                end
                default: state <= S_POR;
            endcase
        end
    end

    // pulse on the edge after the debounced fall; a same-edge reset press wins
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cls_prev  <= 1'b1;
            cls_pulse <= 1'b0;
        end else begin
            cls_prev  <= cls_db;
            cls_pulse <= cls_prev & ~cls_db & rst_db & (state == S_RUN);
        end
    end

    assign cls_level = ~cls_db & rst_db & (state == S_RUN);
    assign rst_state = state;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// tb_board_reset_ctrl: directed bench for board_reset_ctrl.
// Small parameters so every sequence is a few dozen cycles.
`timescale 1ns/1ps
module tb_board_reset_ctrl;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       btn_reset_n;
    logic       btn_cls_n;
    logic       sys_rst_n;
    logic       cls_level;
    logic       cls_pulse;
    logic [1:0] rst_state;

    int passed = 0;
    int total  = 0;

    board_reset_ctrl #(
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .POR_CYCLES       (8),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .btn_reset_n(btn_reset_n),
        .btn_cls_n  (btn_cls_n),
        .sys_rst_n  (sys_rst_n),
        .cls_level  (cls_level),
        .cls_pulse  (cls_pulse),
        .rst_state  (rst_state)
    );

    always #20 clk25 = ~clk25;

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            total++;
            if ({sys_rst_n, rst_state, cls_level, cls_pulse} !== 5'b0) begin
                $display("FAIL reset_hold k=%0d got %b want 00000", k,
                         {sys_rst_n, rst_state, cls_level, cls_pulse});
            end else passed++;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] exp;
            tick(1);
            exp = (k == 8) ? 3'b101 : 3'b000;
            total++;
            if ({sys_rst_n, rst_state} !== exp) begin
                $display("FAIL por_release k=%0d got %b want %b", k,
                         {sys_rst_n, rst_state}, exp);
            end else passed++;
        end
    endtask

    task automatic test_debounce;
        int pulses = 0;
        btn_cls_n = 1'b0;
        tick(3);
        btn_cls_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (cls_pulse || cls_level) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            $display("FAIL glitch got %0d active cycles want 0", pulses);
        end else passed++;
        btn_cls_n = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            logic [1:0] exp;
            if (k == 11) btn_cls_n = 1'b1;
            tick(1);
            exp = {(k >= 6 && k < 16), (k == 7)};
            total++;
            if ({cls_level, cls_pulse} !== exp) begin
                $display("FAIL cls_hold k=%0d got %b want %b", k,
                         {cls_level, cls_pulse}, exp);
            end else passed++;
        end
        tick(4);
    endtask

    task automatic test_reset_button;
        btn_reset_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [2:0] exp;
            tick(1);
            exp = (k < 7) ? 3'b101 : 3'b010;
            total++;
            if ({sys_rst_n, rst_state} !== exp) begin
                $display("FAIL rst_press k=%0d got %b want %b", k,
                         {sys_rst_n, rst_state}, exp);
            end else passed++;
        end
        btn_reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [2:0] exp;
            tick(1);
            exp = (k < 7) ? 3'b010 : (k < 15) ? 3'b011 : 3'b101;
            total++;
            if ({sys_rst_n, rst_state} !== exp) begin
                $display("FAIL rst_release k=%0d got %b want %b", k,
                         {sys_rst_n, rst_state}, exp);
            end else passed++;
        end
        tick(4);
    endtask

    task automatic test_repress;
        int stretch = 0;
        btn_reset_n = 1'b0;
        tick(10);
        btn_reset_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            logic [1:0] exp;
            if (k == 5) btn_reset_n = 1'b0;
            tick(1);
            exp = (k >= 7 && k <= 10) ? 2'd3 : 2'd2;
            total++;
            if (rst_state !== exp) begin
                $display("FAIL repress k=%0d got %0d want %0d", k, rst_state, exp);
            end else passed++;
        end
        btn_reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (rst_state == 2'd3) stretch++;
            total++;
            if (sys_rst_n !== (k >= 15)) begin
                $display("FAIL repress_rel k=%0d got %b want %b", k, sys_rst_n, (k >= 15));
            end else passed++;
        end
        total++;
        if (stretch !== 8) begin
            $display("FAIL stretch_len got %0d want 8", stretch);
        end else passed++;
        tick(4);
    endtask

    task automatic test_simultaneous;
        int bad = 0;
        btn_reset_n = 1'b0;
        btn_cls_n   = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            logic [2:0] exp;
            if (k == 13) begin
                btn_reset_n = 1'b1;
                btn_cls_n   = 1'b1;
            end
            tick(1);
            exp = {(k < 7 || k >= 27), 2'b00};
            total++;
            if ({sys_rst_n, cls_level, cls_pulse} !== exp) begin
                bad++;
                $display("FAIL simult k=%0d got %b want %b", k,
                         {sys_rst_n, cls_level, cls_pulse}, exp);
            end else passed++;
        end
        tick(4);
    endtask

    task automatic test_async_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sys_rst_n, rst_state} !== 3'b000) begin
            $display("FAIL async_run got %b want 000", {sys_rst_n, rst_state});
        end else passed++;
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            total++;
            if (sys_rst_n !== (k == 8)) begin
                $display("FAIL async_por k=%0d got %b want %b", k, sys_rst_n, (k == 8));
            end else passed++;
        end
        btn_reset_n = 1'b0;
        tick(10);
        btn_reset_n = 1'b1;
        tick(9);
        total++;
        if (rst_state !== 2'd3) begin
            $display("FAIL in_stretch got %0d want 3", rst_state);
        end else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sys_rst_n, rst_state} !== 3'b000) begin
            $display("FAIL async_stretch got %b want 000", {sys_rst_n, rst_state});
        end else passed++;
        tick(3);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] exp;
            tick(1);
            exp = (k == 8) ? 3'b101 : 3'b000;
            total++;
            if ({sys_rst_n, rst_state} !== exp) begin
                $display("FAIL restart_por k=%0d got %b want %b", k,
                         {sys_rst_n, rst_state}, exp);
            end else passed++;
        end
        tick(4);
    endtask

    task automatic test_long_press;
        btn_cls_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            logic [1:0] exp;
            if (k == 31) btn_cls_n = 1'b1;
            tick(1);
`ifdef LONG_PRESS_RESET_EN
            exp = {(k < 27 || k >= 35), (k == 7)};
`else
            exp = {1'b1, (k == 7)};
`endif
            total++;
            if ({sys_rst_n, cls_pulse} !== exp) begin
                $display("FAIL long_press k=%0d got %b want %b", k,
                         {sys_rst_n, cls_pulse}, exp);
            end else passed++;
        end
        tick(4);
    endtask

    initial begin
        rst_n       = 1'b0;
        btn_reset_n = 1'b1;
        btn_cls_n   = 1'b1;
        #1;
        test_reset();
        tick(4);
        test_debounce();
        test_reset_button();
        test_repress();
        test_simultaneous();
        test_async_reset();
        test_long_press();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
